// File: rtl/ina_cmd_scheduler_if.sv
// Bundles the UART-receive, I2C-master and result signals of ina_cmd_scheduler.
// slave  : scheduler side (consumes rx/i2c status, drives i2c request + result).
// master : environment side (UART receiver, I2C master, result sink).
interface ina_cmd_scheduler_if;
  logic        rx_valid;   // one-cycle strobe, rx_byte valid
  logic [7:0]  rx_byte;
  logic        i2c_busy;
  logic        i2c_done;   // one-cycle strobe
  logic        i2c_nack;   // valid with i2c_done
  logic [15:0] i2c_rdata;  // valid with i2c_done
  logic        i2c_start;  // one-cycle request
  logic        i2c_rw;     // 1 = read
  logic [6:0]  i2c_addr;
  logic [7:0]  i2c_reg;
  logic [15:0] i2c_wdata;
  logic [23:0] OUT_DATA;
  logic        WEN;        // one-cycle strobe, OUT_DATA valid
  logic        busy;
  logic        ovf;        // one-cycle strobe, frame dropped

  modport slave (
    input  rx_valid, rx_byte, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
    output i2c_start, i2c_rw, i2c_addr, i2c_reg, i2c_wdata, OUT_DATA, WEN, busy, ovf
  );

  modport master (
    output rx_valid, rx_byte, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
    input  i2c_start, i2c_rw, i2c_addr, i2c_reg, i2c_wdata, OUT_DATA, WEN, busy, ovf
  );
endinterface

// File: rtl/ina_cmd_scheduler.sv
// Purpose: assembles 4-byte UART frames (SYNC, CMD, DH, DL) and periodic polls into INA220 I2C ops, one OUT_DATA/WEN per op.
// Latency: DL byte -> i2c_start 3 cycles when idle and I2C free; i2c_done -> WEN 1 cycle.
// Backpressure: one-entry command buffer; a frame finishing while it is full is dropped with an ovf pulse; issue stalls on i2c_busy.
// Ports: PCLK, PRESETN (async active-low) plus bus (ina_cmd_scheduler_if.slave): rx_valid/rx_byte in,
//        i2c_busy/done/nack/rdata in, i2c_start/rw/addr/reg/wdata out, OUT_DATA/WEN/busy/ovf out.
module ina_cmd_scheduler #(
  parameter logic [7:0]  SYNC_BYTE    = 8'h0B,
  parameter logic [6:0]  DEV_BASE     = 7'h40,
  parameter int unsigned POLL_CYCLES  = 50000000,
  parameter logic [7:0]  POLL_CMD     = 8'h82,
  parameter int unsigned BYTE_TIMEOUT = 104166,
  parameter int unsigned I2C_TIMEOUT  = 250000
) (
  input  logic               PCLK,
  input  logic               PRESETN,
  ina_cmd_scheduler_if.slave bus
);

  localparam int BTW = $clog2(BYTE_TIMEOUT + 1);
  localparam int ITW = $clog2(I2C_TIMEOUT + 1);
  localparam int PCW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] dh;
    logic [7:0] dl;
  } cmd_word_t;

  typedef enum logic [1:0] {F_SYNC, F_CMD, F_DH, F_DL} frame_e;
  typedef enum logic [1:0] {EX_IDLE, EX_ISSUE, EX_WAIT, EX_REPORT} ex_e;

  // Frame assembler
  frame_e           frame_q, frame_d;
  logic [BTW-1:0]   btmo_q, btmo_d;
  logic [7:0]       asm_cmd_q, asm_cmd_d;
  logic [7:0]       asm_dh_q, asm_dh_d;
  cmd_word_t        buf_q, buf_d;
  logic             cmd_pending_q, cmd_pending_d;
  logic             ovf_q, ovf_d;
  // Poll timer
  logic [PCW-1:0]   poll_cnt_q, poll_cnt_d;
  logic             poll_pending_q, poll_pending_d;
  logic             poll_tick;
  // Executor
  ex_e              ex_q, ex_d;
  cmd_word_t        op_q, op_d;
  cmd_word_t        sel;
  logic [6:0]       addr_q, addr_d;
  logic             start_q, start_d;
  logic             wen_q, wen_d;
  logic [23:0]      out_q, out_d;
  logic [ITW-1:0]   itmo_q, itmo_d;
  logic             cmd_take, poll_take;

  // ---------------- frame FSM ----------------
  always_comb begin
    frame_d       = frame_q;
    asm_cmd_d     = asm_cmd_q;
    asm_dh_d      = asm_dh_q;
    buf_d         = buf_q;
    cmd_pending_d = cmd_pending_q & ~cmd_take;
    ovf_d         = 1'b0;
    btmo_d        = (frame_q == F_SYNC) ? '0 : btmo_q + 1'b1;
    if (bus.rx_valid) begin
      btmo_d = '0;
      case (frame_q)
        F_SYNC: if (bus.rx_byte == SYNC_BYTE) frame_d = F_CMD;
        F_CMD: begin
          asm_cmd_d = bus.rx_byte;
          frame_d   = F_DH;
        end
        F_DH: begin
          asm_dh_d = bus.rx_byte;
          frame_d  = F_DL;
        end
        default: begin
          frame_d = F_SYNC;
          // The executor emptying the buffer this very cycle frees the slot.
          if (!cmd_pending_q || cmd_take) begin
            buf_d         = {asm_cmd_q, asm_dh_q, bus.rx_byte};
            cmd_pending_d = 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
        end
      endcase
    end else if (frame_q != F_SYNC && btmo_q == BTW'(BYTE_TIMEOUT - 1)) begin
      frame_d = F_SYNC;
    end
  end

  // ---------------- poll timer ----------------
  // A tick while a poll is still pending merges into it.
  always_comb begin
    poll_tick      = (POLL_CYCLES != 0) && (poll_cnt_q == PCW'(POLL_CYCLES - 1));
    poll_cnt_d     = (POLL_CYCLES == 0 || poll_tick) ? '0 : poll_cnt_q + 1'b1;
    poll_pending_d = (poll_pending_q & ~poll_take) | poll_tick;
  end

  // ---------------- executor FSM ----------------
  always_comb begin
    ex_d      = ex_q;
    op_d      = op_q;
    addr_d    = addr_q;
    start_d   = 1'b0;
    wen_d     = 1'b0;
    out_d     = out_q;
    itmo_d    = itmo_q;
    cmd_take  = 1'b0;
    poll_take = 1'b0;
    sel       = cmd_pending_q ? buf_q : {POLL_CMD, 16'h0000};
    case (ex_q)
      EX_IDLE: begin
        if (cmd_pending_q || poll_pending_q) begin
          cmd_take  = cmd_pending_q;
          poll_take = ~cmd_pending_q;
          op_d      = sel;
          addr_d    = DEV_BASE + {4'b0000, sel.cmd[6:4]};
          ex_d      = EX_ISSUE;
        end
      end
      EX_ISSUE: begin
        if (!bus.i2c_busy) begin
          start_d = 1'b1;
          itmo_d  = '0;
          ex_d    = EX_WAIT;
        end
      end
      EX_WAIT: begin
        itmo_d = itmo_q + 1'b1;
        if (bus.i2c_done) begin
          wen_d = 1'b1;
          ex_d  = EX_REPORT;
          if (bus.i2c_nack)     out_d = {8'hFF, op_q.cmd, 8'h00};
          else if (op_q.cmd[7]) out_d = {op_q.cmd, bus.i2c_rdata};
          else                  out_d = op_q;
        end else if (itmo_q == ITW'(I2C_TIMEOUT - 1)) begin
          wen_d = 1'b1;
          ex_d  = EX_REPORT;
          out_d = {8'hFE, op_q.cmd, 8'h00};
        end
      end
      default: ex_d = EX_IDLE;  // EX_REPORT: WEN is high for this one cycle
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      frame_q        <= F_SYNC;
      btmo_q         <= '0;
      asm_cmd_q      <= '0;
      asm_dh_q       <= '0;
      buf_q          <= '0;
      cmd_pending_q  <= 1'b0;
      ovf_q          <= 1'b0;
      poll_cnt_q     <= '0;
      poll_pending_q <= 1'b0;
      ex_q           <= EX_IDLE;
      op_q           <= '0;
      addr_q         <= '0;
      start_q        <= 1'b0;
      wen_q          <= 1'b0;
      out_q          <= '0;
      itmo_q         <= '0;
    end else begin
      frame_q        <= frame_d;
      btmo_q         <= btmo_d;
      asm_cmd_q      <= asm_cmd_d;
      asm_dh_q       <= asm_dh_d;
      buf_q          <= buf_d;
      cmd_pending_q  <= cmd_pending_d;
      ovf_q          <= ovf_d;
      poll_cnt_q     <= poll_cnt_d;
      poll_pending_q <= poll_pending_d;
      ex_q           <= ex_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      start_q        <= start_d;
      wen_q          <= wen_d;
      out_q          <= out_d;
      itmo_q         <= itmo_d;
    end
  end

  assign bus.i2c_start = start_q;
  assign bus.i2c_rw    = op_q.cmd[7];
  assign bus.i2c_addr  = addr_q;
  assign bus.i2c_reg   = {4'h0, op_q.cmd[3:0]};
  assign bus.i2c_wdata = {op_q.dh, op_q.dl};
  assign bus.OUT_DATA  = out_q;
  assign bus.WEN       = wen_q;
  assign bus.busy      = (ex_q != EX_IDLE);
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ina_cmd_scheduler.sv
module tb_ina_cmd_scheduler;
  localparam int BT = 40;
  localparam int IT = 50;
  localparam int PC = 100;

  logic PCLK = 1'b0;
  logic PRESETN;
  int tests_run = 0;
  int tests_failed = 0;
  logic [23:0] exp_q[$];
  logic [23:0] pexp_q[$];
  logic [23:0] e0, e1;
  bit pmon_en = 1'b0;

  ina_cmd_scheduler_if bus0();
  ina_cmd_scheduler_if bus1();

  ina_cmd_scheduler #(.POLL_CYCLES(0), .BYTE_TIMEOUT(BT), .I2C_TIMEOUT(IT)) u_dut (
    .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus0));
  ina_cmd_scheduler #(.POLL_CYCLES(PC), .BYTE_TIMEOUT(BT), .I2C_TIMEOUT(IT)) u_poll (
    .PCLK(PCLK), .PRESETN(PRESETN), .bus(bus1));

  always #5 PCLK = ~PCLK;

  // Scoreboards: every WEN pops one expected word.
  always @(negedge PCLK) begin
    if (bus0.WEN === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL wen_unexpected: got OUT_DATA=%h, required no WEN", bus0.OUT_DATA);
      end else begin
        e0 = exp_q.pop_front();
        if (bus0.OUT_DATA !== e0) begin
          tests_failed++;
          $display("FAIL wen_data: got %h, required %h", bus0.OUT_DATA, e0);
        end
      end
    end
    if (pmon_en && bus1.WEN === 1'b1) begin
      tests_run++;
      if (pexp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL poll_wen_unexpected: got OUT_DATA=%h, required no WEN", bus1.OUT_DATA);
      end else begin
        e1 = pexp_q.pop_front();
        if (bus1.OUT_DATA !== e1) begin
          tests_failed++;
          $display("FAIL poll_wen_data: got %h, required %h", bus1.OUT_DATA, e1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input bit p, input logic [7:0] b);
    if (p) begin bus1.rx_valid = 1'b1; bus1.rx_byte = b; end
    else   begin bus0.rx_valid = 1'b1; bus0.rx_byte = b; end
    tick();
    bus0.rx_valid = 1'b0;
    bus1.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input bit p, input logic [7:0] c, input logic [7:0] dh, input logic [7:0] dl);
    send_byte(p, 8'h0B);
    send_byte(p, c);
    send_byte(p, dh);
    send_byte(p, dl);
  endtask

  task automatic drive_done(input bit p, input bit nack, input logic [15:0] rd);
    if (p) begin bus1.i2c_done = 1'b1; bus1.i2c_nack = nack; bus1.i2c_rdata = rd; end
    else   begin bus0.i2c_done = 1'b1; bus0.i2c_nack = nack; bus0.i2c_rdata = rd; end
    tick();
    bus0.i2c_done = 1'b0; bus0.i2c_nack = 1'b0;
    bus1.i2c_done = 1'b0; bus1.i2c_nack = 1'b0;
  endtask

  task automatic wait_start(input bit p, input int limit, output int n, output bit found);
    found = 1'b0;
    n = 0;
    while (!found && n < limit) begin
      tick();
      n++;
      if ((p ? bus1.i2c_start : bus0.i2c_start) === 1'b1) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle(3);
    tests_run++;
    if ({bus0.i2c_start, bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata,
         bus0.OUT_DATA, bus0.WEN, bus0.busy, bus0.ovf} !== 61'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got addr=%h data=%h busy=%b, required all 0", bus0.i2c_addr, bus0.OUT_DATA, bus0.busy);
    end
    tests_run++;
    if ({bus1.i2c_start, bus1.i2c_addr, bus1.OUT_DATA, bus1.WEN, bus1.busy} !== 34'd0) begin
      tests_failed++;
      $display("FAIL reset_poll_outputs: got addr=%h busy=%b, required all 0", bus1.i2c_addr, bus1.busy);
    end
    PRESETN = 1'b1;
    idle(2);
    tests_run++;
    if (bus0.busy !== 1'b0 || bus0.i2c_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_idle: got busy=%b start=%b, required 0 0", bus0.busy, bus0.i2c_start);
    end
  endtask

  task automatic test_read();
    int n; bit f;
    send_byte(0, 8'h55);  // stray byte while hunting for sync
    exp_q.push_back(24'h8A1234);
    send_frame(0, 8'h8A, 8'h8C, 8'hCA);
    wait_start(0, 10, n, f);
    tests_run++;
    if (!f || n != 2) begin
      tests_failed++;
      $display("FAIL read_latency: got found=%0d cycles=%0d, required found=1 cycles=2", f, n);
    end
    tests_run++;
    if ({bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg} !== {1'b1, 7'h40, 8'h0A}) begin
      tests_failed++;
      $display("FAIL read_fields: got rw=%b addr=%h reg=%h, required 1 40 0a", bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg);
    end
    tests_run++;
    if (bus0.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL read_busy: got %b, required 1", bus0.busy);
    end
    drive_done(0, 1'b0, 16'h1234);
    tests_run++;
    if (bus0.WEN !== 1'b1) begin
      tests_failed++;
      $display("FAIL done_to_wen: got WEN=%b one cycle after done, required 1", bus0.WEN);
    end
    idle(3);
    tests_run++;
    if (bus0.OUT_DATA !== 24'h8A1234 || bus0.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_hold: got data=%h busy=%b, required 8a1234 0", bus0.OUT_DATA, bus0.busy);
    end
  endtask

  task automatic test_write();
    int n; bit f;
    exp_q.push_back(24'h158CCA);
    send_frame(0, 8'h15, 8'h8C, 8'hCA);
    wait_start(0, 10, n, f);
    tests_run++;
    if (!f || {bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata} !== {1'b0, 7'h41, 8'h05, 16'h8CCA}) begin
      tests_failed++;
      $display("FAIL write_fields: got found=%0d rw=%b addr=%h reg=%h wdata=%h, required 1 0 41 05 8cca",
               f, bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata);
    end
    drive_done(0, 1'b0, 16'hFFFF);
    idle(3);
  endtask

  task automatic test_nack_timeout();
    int n; bit f; bit got;
    exp_q.push_back(24'hFF8A00);
    send_frame(0, 8'h8A, 8'h00, 8'h00);
    wait_start(0, 10, n, f);
    tests_run++;
    if (!f) begin
      tests_failed++;
      $display("FAIL nack_start: got no i2c_start in %0d cycles, required one", n);
    end
    drive_done(0, 1'b1, 16'hBEEF);
    idle(2);
    exp_q.push_back(24'hFE8A00);
    send_frame(0, 8'h8A, 8'h00, 8'h00);
    wait_start(0, 10, n, f);
    got = 1'b0;
    n = 0;
    while (!got && n < IT + 20) begin
      tick();
      n++;
      if (bus0.WEN === 1'b1) got = 1'b1;
    end
    tests_run++;
    if (!f || !got || n != IT) begin
      tests_failed++;
      $display("FAIL i2c_timeout: got start=%0d wen=%0d after %0d cycles, required 1 1 after %0d", f, got, n, IT);
    end
    idle(2);
    drive_done(0, 1'b0, 16'h0000);  // late done, must be ignored
    idle(5);
    tests_run++;
    if (bus0.busy !== 1'b0 || bus0.OUT_DATA !== 24'hFE8A00) begin
      tests_failed++;
      $display("FAIL late_done: got busy=%b data=%h, required 0 fe8a00", bus0.busy, bus0.OUT_DATA);
    end
  endtask

  task automatic test_byte_timeout();
    int n; bit f;
    // Gap one cycle short of the timeout: frame continues.
    exp_q.push_back(24'h160007);
    send_byte(0, 8'h0B);
    send_byte(0, 8'h16);
    idle(BT - 1);
    send_byte(0, 8'h00);
    send_byte(0, 8'h07);
    wait_start(0, 10, n, f);
    tests_run++;
    if (!f || {bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata} !== {7'h41, 8'h06, 16'h0007}) begin
      tests_failed++;
      $display("FAIL gap_below_timeout: got found=%0d addr=%h reg=%h wdata=%h, required 1 41 06 0007",
               f, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata);
    end
    drive_done(0, 1'b0, 16'h0000);
    idle(3);
    // Gap past the timeout: partial frame discarded.
    exp_q.push_back(24'h050001);
    send_byte(0, 8'h0B);
    send_byte(0, 8'h8A);
    idle(BT + 1);
    send_frame(0, 8'h05, 8'h00, 8'h01);
    wait_start(0, 10, n, f);
    tests_run++;
    if (!f || {bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata} !== {1'b0, 7'h40, 8'h05, 16'h0001}) begin
      tests_failed++;
      $display("FAIL byte_timeout: got found=%0d rw=%b addr=%h reg=%h wdata=%h, required 1 0 40 05 0001",
               f, bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata);
    end
    drive_done(0, 1'b0, 16'h0000);
    idle(3);
  endtask

  task automatic test_overflow_reset();
    int n; bit f;
    bus0.i2c_busy = 1'b1;
    exp_q.push_back(24'h8A5678);
    send_frame(0, 8'h8A, 8'h00, 8'h01);   // taken by executor, stalls in issue
    send_frame(0, 8'h16, 8'hAB, 8'hCD);   // fills the buffer
    tests_run++;
    if (bus0.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_false: got %b, required 0", bus0.ovf);
    end
    send_frame(0, 8'h8A, 8'h11, 8'h22);   // buffer full: dropped
    tests_run++;
    if (bus0.ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_pulse: got %b, required 1", bus0.ovf);
    end
    tick();
    tests_run++;
    if (bus0.ovf !== 1'b0 || bus0.busy !== 1'b1 || bus0.i2c_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_one_cycle: got ovf=%b busy=%b start=%b, required 0 1 0", bus0.ovf, bus0.busy, bus0.i2c_start);
    end
    bus0.i2c_busy = 1'b0;
    wait_start(0, 5, n, f);
    tests_run++;
    if (!f || {bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg} !== {1'b1, 7'h40, 8'h0A}) begin
      tests_failed++;
      $display("FAIL busy_release: got found=%0d rw=%b addr=%h reg=%h, required 1 1 40 0a", f, bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg);
    end
    drive_done(0, 1'b0, 16'h5678);
    wait_start(0, 10, n, f);
    tests_run++;
    if (!f || {bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata} !== {1'b0, 7'h41, 8'h06, 16'hABCD}) begin
      tests_failed++;
      $display("FAIL buffered_frame: got found=%0d rw=%b addr=%h reg=%h wdata=%h, required 1 0 41 06 abcd",
               f, bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata);
    end
    idle(3);
    PRESETN = 1'b0;
    #1;
    tests_run++;
    if ({bus0.i2c_start, bus0.i2c_rw, bus0.i2c_addr, bus0.i2c_reg, bus0.i2c_wdata,
         bus0.OUT_DATA, bus0.WEN, bus0.busy, bus0.ovf} !== 61'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_wait: got addr=%h wdata=%h data=%h busy=%b, required all 0",
               bus0.i2c_addr, bus0.i2c_wdata, bus0.OUT_DATA, bus0.busy);
    end
    idle(3);
    PRESETN = 1'b1;
    drive_done(0, 1'b0, 16'h9999);
    idle(10);
    tests_run++;
    if (bus0.busy !== 1'b0 || bus0.OUT_DATA !== 24'h000000) begin
      tests_failed++;
      $display("FAIL after_abort: got busy=%b data=%h, required 0 000000", bus0.busy, bus0.OUT_DATA);
    end
  endtask

  task automatic test_poll();
    int n; bit f;
    PRESETN = 1'b0;
    idle(2);
    pmon_en = 1'b1;
    PRESETN = 1'b1;
    idle(PC - 4);
    // DL lands on the edge where the poll counter hits its terminal count.
    pexp_q.push_back(24'h931111);
    send_frame(1, 8'h93, 8'h00, 8'h00);
    pexp_q.push_back(24'h820ABC);
    wait_start(1, 10, n, f);
    tests_run++;
    if (!f || {bus1.i2c_rw, bus1.i2c_addr, bus1.i2c_reg} !== {1'b1, 7'h41, 8'h03}) begin
      tests_failed++;
      $display("FAIL cmd_priority: got found=%0d rw=%b addr=%h reg=%h, required 1 1 41 03", f, bus1.i2c_rw, bus1.i2c_addr, bus1.i2c_reg);
    end
    drive_done(1, 1'b0, 16'h1111);
    wait_start(1, 10, n, f);
    tests_run++;
    if (!f || {bus1.i2c_rw, bus1.i2c_addr, bus1.i2c_reg} !== {1'b1, 7'h40, 8'h02}) begin
      tests_failed++;
      $display("FAIL poll_issue: got found=%0d rw=%b addr=%h reg=%h, required 1 1 40 02", f, bus1.i2c_rw, bus1.i2c_addr, bus1.i2c_reg);
    end
    drive_done(1, 1'b0, 16'h0ABC);
    tests_run++;
    if (bus1.WEN !== 1'b1 || bus1.OUT_DATA[23:16] !== 8'h82) begin
      tests_failed++;
      $display("FAIL poll_report: got WEN=%b cmd=%h, required 1 82", bus1.WEN, bus1.OUT_DATA[23:16]);
    end
    idle(3);
    pmon_en = 1'b0;
  endtask

  initial begin
    PRESETN = 1'b0;
    bus0.rx_valid = 1'b0; bus0.rx_byte = 8'h00; bus0.i2c_busy = 1'b0;
    bus0.i2c_done = 1'b0; bus0.i2c_nack = 1'b0; bus0.i2c_rdata = 16'h0000;
    bus1.rx_valid = 1'b0; bus1.rx_byte = 8'h00; bus1.i2c_busy = 1'b0;
    bus1.i2c_done = 1'b0; bus1.i2c_nack = 1'b0; bus1.i2c_rdata = 16'h0000;
    test_reset();
    test_read();
    test_write();
    test_nack_timeout();
    test_byte_timeout();
    test_overflow_reset();
    test_poll();
    tests_run++;
    if (exp_q.size() != 0 || pexp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_wen: got %0d and %0d reports outstanding, required 0 0", exp_q.size(), pexp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
